// File: rtl/sdr_bank_tracker.sv
// Passive SDRAM command-bus observer: tracks per-bank state, open rows and
// timing/protocol violations for the bus protocol checker.
module sdr_bank_tracker #(
  parameter int unsigned TRP       = 3,
  parameter int unsigned TRCD      = 3,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        sdram_clk,
  input  logic        sdram_reset,
  input  logic        sdr_cke,
  input  logic        sdr_cs_n,
  input  logic        sdr_ras_n,
  input  logic        sdr_cas_n,
  input  logic        sdr_we_n,
  input  logic [1:0]  sdr_ba,
  input  logic [12:0] sdr_addr,
  output logic [11:0] bank_st,
  output logic [3:0]  bank_open,
  output logic [51:0] open_row,
  output logic        err_valid,
  output logic [2:0]  err_code,
  output logic [1:0]  err_bank
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_PRE  = 3'b001,
    ST_ACT  = 3'b010,
    ST_XFR  = 3'b011,
    ST_DLP  = 3'b100
  } bank_state_e;

  typedef enum logic [3:0] {
    CMD_LMR = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_BST = 4'b0110,
    CMD_NOP = 4'b0111
  } cmd_e;

  localparam logic [CNT_W-1:0] TRP_LD  = CNT_W'(TRP - 1);
  localparam logic [CNT_W-1:0] TRCD_LD = CNT_W'(TRCD - 1);
  localparam logic [CNT_W-1:0] BL_LD   = CNT_W'(BURST_LEN - 1);

  bank_state_e      st_q  [4];
  bank_state_e      st_d  [4];
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [12:0]      row_q [4];
  logic [12:0]      row_d [4];

  logic       err_valid_q, err_valid_d;
  logic [2:0] err_code_q,  err_code_d;
  logic [1:0] err_bank_q,  err_bank_d;

  cmd_e       cmd;
  logic       a10;
  logic       any_busy;
  logic [1:0] low_busy;

  assign a10 = sdr_addr[10];

  always_comb begin
    if (sdr_cke && !sdr_cs_n) cmd = cmd_e'({1'b0, sdr_ras_n, sdr_cas_n, sdr_we_n});
    else                      cmd = CMD_NOP;
  end

  always_comb begin
    any_busy = 1'b0;
    low_busy = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (!any_busy && st_q[b] != ST_IDLE) begin
        any_busy = 1'b1;
        low_busy = 2'(b);
      end
    end
  end

  always_comb begin
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    err_bank_d  = err_bank_q;

    // Timed progress first; a command on this edge then overrides its bank.
    for (int unsigned b = 0; b < 4; b++) begin
      st_d[b]  = st_q[b];
      row_d[b] = row_q[b];
      cnt_d[b] = (cnt_q[b] == '0) ? '0 : cnt_q[b] - CNT_W'(1);
      case (st_q[b])
        ST_XFR: if (cnt_q[b] == '0) st_d[b] = ST_ACT;
        ST_DLP: if (cnt_q[b] == '0) begin
          st_d[b]  = ST_PRE;
          cnt_d[b] = TRP_LD;
        end
        ST_PRE: if (cnt_q[b] == '0) st_d[b] = ST_IDLE;
        default: ;
      endcase
    end

    case (cmd)
      CMD_ACT: begin
        if (st_q[sdr_ba] == ST_IDLE) begin
          st_d[sdr_ba]  = ST_ACT;
          cnt_d[sdr_ba] = TRCD_LD;
          row_d[sdr_ba] = sdr_addr;
        end else if (st_q[sdr_ba] != ST_DLP) begin
          err_valid_d = 1'b1;
          err_code_d  = 3'd1;
          err_bank_d  = sdr_ba;
        end
      end
      CMD_RD, CMD_WR: begin
        case (st_q[sdr_ba])
          ST_IDLE, ST_PRE: begin
            err_valid_d = 1'b1;
            err_code_d  = 3'd2;
            err_bank_d  = sdr_ba;
          end
          ST_ACT, ST_XFR: begin
            if (st_q[sdr_ba] == ST_ACT && cnt_q[sdr_ba] != '0) begin
              err_valid_d = 1'b1;
              err_code_d  = 3'd3;
              err_bank_d  = sdr_ba;
            end else begin
              st_d[sdr_ba]  = a10 ? ST_DLP : ST_XFR;
              cnt_d[sdr_ba] = BL_LD;
            end
          end
          default: ;
        endcase
      end
      CMD_BST: begin
        if (st_q[sdr_ba] == ST_XFR) begin
          st_d[sdr_ba]  = ST_ACT;
          cnt_d[sdr_ba] = '0;
        end
      end
      CMD_PRE: begin
        for (int unsigned b = 0; b < 4; b++) begin
          if ((a10 || sdr_ba == 2'(b)) && (st_q[b] == ST_ACT || st_q[b] == ST_XFR)) begin
            st_d[b]  = ST_PRE;
            cnt_d[b] = TRP_LD;
          end
        end
      end
      CMD_REF, CMD_LMR: begin
        if (any_busy) begin
          err_valid_d = 1'b1;
          err_code_d  = (cmd == CMD_REF) ? 3'd4 : 3'd5;
          err_bank_d  = low_busy;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_reset) begin
      for (int unsigned b = 0; b < 4; b++) begin
        st_q[b]  <= ST_IDLE;
        cnt_q[b] <= '0;
        row_q[b] <= '0;
      end
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      err_bank_q  <= '0;
    end else begin
      for (int unsigned b = 0; b < 4; b++) begin
        st_q[b]  <= st_d[b];
        cnt_q[b] <= cnt_d[b];
        row_q[b] <= row_d[b];
      end
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_bank_q  <= err_bank_d;
    end
  end

  always_comb begin
    bank_st   = '0;
    bank_open = '0;
    open_row  = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      bank_st[3*b +: 3]   = st_q[b];
      bank_open[b]        = (st_q[b] == ST_ACT) || (st_q[b] == ST_XFR) || (st_q[b] == ST_DLP);
      open_row[13*b +: 13] = row_q[b];
    end
  end

  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_bank  = err_bank_q;

endmodule

// File: tb/tb_sdr_bank_tracker.sv
// Directed bench for sdr_bank_tracker: deadline-based bank model checked every
// cycle, plus literal pins taken from hand-worked command sequences.
module tb_sdr_bank_tracker;
  localparam int TRP  = 2;
  localparam int TRCD = 2;
  localparam int BL   = 4;

  localparam logic [3:0] C_LMR = 4'b0000, C_REF = 4'b0001, C_PRE = 4'b0010,
                         C_ACT = 4'b0011, C_WR  = 4'b0100, C_RD  = 4'b0101,
                         C_BST = 4'b0110, C_NOP = 4'b0111;

  // Model phases; each timed phase ends at an absolute edge number.
  localparam int M_IDLE = 0, M_OPEN = 1, M_BURST = 2, M_BAP = 3, M_PRE = 4;

  logic        clk = 1'b0;
  logic        sdram_reset = 1'b1;
  logic        sdr_cke = 1'b1, sdr_cs_n = 1'b0, sdr_ras_n = 1'b1, sdr_cas_n = 1'b1, sdr_we_n = 1'b1;
  logic [1:0]  sdr_ba = '0;
  logic [12:0] sdr_addr = '0;
  logic [11:0] bank_st;
  logic [3:0]  bank_open;
  logic [51:0] open_row;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [1:0]  err_bank;

  always #5 clk = ~clk;

  sdr_bank_tracker #(.TRP(TRP), .TRCD(TRCD), .BURST_LEN(BL), .CNT_W(4)) dut (
    .sdram_clk(clk), .sdram_reset(sdram_reset), .sdr_cke(sdr_cke),
    .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n), .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n),
    .sdr_ba(sdr_ba), .sdr_addr(sdr_addr),
    .bank_st(bank_st), .bank_open(bank_open), .open_row(open_row),
    .err_valid(err_valid), .err_code(err_code), .err_bank(err_bank)
  );

  int checks = 0;
  int failures = 0;

  int          ph [4];
  int          t_end [4];
  int          t_act [4];
  logic [12:0] m_row [4];
  int          n = 0;
  logic        chk_en = 1'b0;

  logic [11:0] exp_st = '0;
  logic [3:0]  exp_open = '0;
  logic [51:0] exp_row = '0;
  logic        exp_ev = 1'b0;
  logic [2:0]  exp_code = '0;
  logic [1:0]  exp_bank = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // State a command issued at edge m would see.
  function automatic int view(int b, int m);
    case (ph[b])
      M_BURST: return (m > t_end[b]) ? M_OPEN : M_BURST;
      M_BAP: begin
        if (m <= t_end[b]) return M_BAP;
        if (m <= t_end[b] + TRP) return M_PRE;
        return M_IDLE;
      end
      M_PRE:   return (m > t_end[b]) ? M_IDLE : M_PRE;
      default: return ph[b];
    endcase
  endfunction

  function automatic logic [2:0] enc(int p);
    case (p)
      M_OPEN:  return 3'b010;
      M_BURST: return 3'b011;
      M_BAP:   return 3'b100;
      M_PRE:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic flag(input logic [2:0] code, input logic [1:0] bank);
    exp_ev = 1'b1; exp_code = code; exp_bank = bank;
  endtask

  task automatic model_edge(input logic rst, input logic cke, input logic [3:0] c,
                            input logic [1:0] ba, input logic [12:0] addr);
    int v;
    exp_ev = 1'b0;
    if (rst) begin
      for (int b = 0; b < 4; b++) begin ph[b] = M_IDLE; m_row[b] = '0; t_act[b] = 0; t_end[b] = 0; end
    end else begin
      for (int b = 0; b < 4; b++) begin
        v = view(b, n);
        if (ph[b] == M_BAP && v == M_PRE) t_end[b] += TRP;
        ph[b] = v;
      end
      if (cke && !c[3]) begin
        case (c)
          C_ACT: begin
            if (ph[ba] == M_IDLE) begin ph[ba] = M_OPEN; t_act[ba] = n; m_row[ba] = addr; end
            else if (ph[ba] != M_BAP) flag(3'd1, ba);
          end
          C_RD, C_WR: begin
            if (ph[ba] == M_IDLE || ph[ba] == M_PRE) flag(3'd2, ba);
            else if (ph[ba] == M_OPEN && n - t_act[ba] < TRCD) flag(3'd3, ba);
            else if (ph[ba] == M_OPEN || ph[ba] == M_BURST) begin
              ph[ba] = addr[10] ? M_BAP : M_BURST;
              t_end[ba] = n + BL;
            end
          end
          C_BST: if (ph[ba] == M_BURST) ph[ba] = M_OPEN;
          C_PRE: begin
            for (int b = 0; b < 4; b++)
              if ((addr[10] || int'(ba) == b) && (ph[b] == M_OPEN || ph[b] == M_BURST)) begin
                ph[b] = M_PRE; t_end[b] = n + TRP;
              end
          end
          C_REF, C_LMR: begin
            for (int b = 3; b >= 0; b--)
              if (ph[b] != M_IDLE) flag((c == C_REF) ? 3'd4 : 3'd5, 2'(b));
          end
          default: ;
        endcase
      end
    end
    n++;
    for (int b = 0; b < 4; b++) begin
      v = view(b, n);
      exp_st[3*b +: 3] = enc(v);
      exp_open[b] = (v == M_OPEN) || (v == M_BURST) || (v == M_BAP);
      exp_row[13*b +: 13] = m_row[b];
    end
  endtask

  // Returns before the edge that samples these inputs, so outputs visible on
  // return reflect the previous call's command.
  task automatic cyc(input logic rst, input logic cke, input logic [3:0] c,
                     input logic [1:0] ba, input logic [12:0] addr);
    @(negedge clk); #1;
    sdram_reset = rst; sdr_cke = cke;
    {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = c;
    sdr_ba = ba; sdr_addr = addr;
    model_edge(rst, cke, c, ba, addr);
    chk_en = 1'b1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr);
    cyc(1'b0, 1'b1, c, ba, addr);
  endtask

  task automatic nop();
    issue(C_NOP, 2'd0, 13'h0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("bank_st", 64'(bank_st), 64'(exp_st));
      check("bank_open", 64'(bank_open), 64'(exp_open));
      check("open_row", 64'(open_row), 64'(exp_row));
      check("err_valid", 64'(err_valid), 64'(exp_ev));
      if (exp_ev) begin
        check("err_code", 64'(err_code), 64'(exp_code));
        check("err_bank", 64'(err_bank), 64'(exp_bank));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1'b1, 1'b1, C_NOP, 2'd0, 13'h0);
    cyc(1'b1, 1'b1, C_NOP, 2'd0, 13'h0);
    nop();
    check("rst_st", 64'(bank_st), 64'h0);
    check("rst_open", 64'(bank_open), 64'h0);
    check("rst_row", 64'(open_row), 64'h0);
    check("rst_err", 64'(err_valid), 64'h0);
    check("rst_code", 64'(err_code), 64'h0);

    issue(C_ACT, 2'd1, 13'h1A5); nop();
    check("act1_st", 64'(bank_st), 64'h010);
    check("act1_open", 64'(bank_open), 64'b0010);
    check("act1_row", 64'(open_row[25:13]), 64'h1A5);
    check("act1_err", 64'(err_valid), 64'h0);

    issue(C_ACT, 2'd0, 13'h042); issue(C_RD, 2'd0, 13'h0); issue(C_RD, 2'd0, 13'h0);
    check("trcd_ev", 64'(err_valid), 64'h1);
    check("trcd_code", 64'(err_code), 64'd3);
    check("trcd_bank", 64'(err_bank), 64'd0);
    check("trcd_st", 64'(bank_st[2:0]), 64'b010);
    nop();
    check("rd_xfr0", 64'(bank_st[2:0]), 64'b011);
    nop(); nop(); nop();
    check("rd_xfr3", 64'(bank_st[2:0]), 64'b011);
    nop();
    check("rd_done", 64'(bank_st[2:0]), 64'b010);

    issue(C_ACT, 2'd2, 13'h777); nop(); nop(); issue(C_WR, 2'd2, 13'h400);
    issue(C_ACT, 2'd2, 13'h123);
    check("ap_dlp", 64'(bank_st[8:6]), 64'b100);
    check("ap_open", 64'(bank_open[2]), 64'h1);
    nop();
    check("ap_ign_err", 64'(err_valid), 64'h0);
    nop(); nop(); nop();
    check("ap_pre", 64'(bank_st[8:6]), 64'b001);
    check("ap_closed", 64'(bank_open[2]), 64'h0);
    nop(); nop();
    check("ap_idle", 64'(bank_st[8:6]), 64'b000);
    check("ap_row", 64'(open_row[38:26]), 64'h777);
    issue(C_RD, 2'd2, 13'h0); nop();
    check("rd_idle_code", 64'(err_code), 64'd2);
    check("rd_idle_bank", 64'(err_bank), 64'd2);

    issue(C_PRE, 2'd1, 13'h0); issue(C_PRE, 2'd2, 13'h0);
    issue(C_ACT, 2'd3, 13'h0F0); nop(); nop();
    issue(C_PRE, 2'd2, 13'h400); nop();
    check("pall_pre0", 64'(bank_st), 64'h201);
    nop();
    check("pall_pre1", 64'(bank_st), 64'h201);
    nop();
    check("pall_idle", 64'(bank_st), 64'h000);
    issue(C_REF, 2'd0, 13'h0); nop();
    check("ref_ok", 64'(err_valid), 64'h0);

    issue(C_ACT, 2'd3, 13'h0F1); nop(); issue(C_PRE, 2'd3, 13'h0);
    issue(C_REF, 2'd0, 13'h0); issue(C_LMR, 2'd0, 13'h0);
    check("ref_code", 64'(err_code), 64'd4);
    check("ref_bank", 64'(err_bank), 64'd3);
    issue(C_REF, 2'd0, 13'h0);
    check("lmr_code", 64'(err_code), 64'd5);
    check("lmr_bank", 64'(err_bank), 64'd3);
    nop();
    check("ref_late_ok", 64'(err_valid), 64'h0);

    issue(C_ACT, 2'd0, 13'h055); nop(); issue(C_RD, 2'd0, 13'h0); issue(C_BST, 2'd0, 13'h0); nop();
    check("bst_act", 64'(bank_st[2:0]), 64'b010);
    issue(C_ACT, 2'd0, 13'h0AA); nop();
    check("react_code", 64'(err_code), 64'd1);
    check("react_row", 64'(open_row[12:0]), 64'h055);
    issue(C_WR, 2'd0, 13'h0); issue(C_RD, 2'd0, 13'h400); nop();
    check("restart_dlp", 64'(bank_st[2:0]), 64'b100);
    for (int i = 0; i < 8; i++) nop();

    issue(C_ACT, 2'd1, 13'h1FF); nop(); nop(); issue(C_RD, 2'd1, 13'h0); nop();
    cyc(1'b1, 1'b0, C_NOP, 2'd0, 13'h0);
    cyc(1'b0, 1'b0, C_ACT, 2'd0, 13'h010);
    check("mrst_st", 64'(bank_st), 64'h0);
    check("mrst_err", 64'(err_valid), 64'h0);
    check("mrst_row", 64'(open_row), 64'h0);
    cyc(1'b0, 1'b0, C_RD, 2'd1, 13'h0);
    check("cke0_act", 64'(bank_st), 64'h0);
    nop();
    check("cke0_rd_st", 64'(bank_st), 64'h0);
    check("cke0_rd_err", 64'(err_valid), 64'h0);

    @(negedge clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
